// File: rtl/cpu_data_path.sv
// cpu_data_path
// Datapath stage that sits behind the microcontroller control unit. It holds
// the PC, MAR, IR, a 16x8 register file, the 8-bit ALU with its CCR, and a
// branch-target latch. Two bus multiplexers route data between them.
//
// Ports:
//   clk, reset            - system clock, asynchronous active-low reset
//   IR_Load/MAR_Load      - load IR / MAR from Bus2
//   PC_Load/PC_Inc        - PC <= branch target / PC <= PC+1 (Load wins)
//   reg_read_addr_A/B     - asynchronous register-file read ports
//   reg_write_addr/enable - register-file write of Bus2
//   ALU_Sel, CCR_Load     - ALU opcode, latch {N,Z,V,C} into CCR
//   Bus1_Sel, Bus2_Sel    - bus multiplexer selects
//   ALU_B_Sel, addr_sel   - ALU operand-select qualifiers
//   immediate_in          - immediate / branch offset
//   from_memory           - memory read data
//   IR, address, pc_out   - registered state outputs
//   to_memory             - Bus1, combinational
//   CCR_Result            - {N,Z,V,C}
module cpu_data_path #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IR_Load,
    input  logic              MAR_Load,
    input  logic              PC_Load,
    input  logic              PC_Inc,
    input  logic [3:0]        reg_read_addr_A,
    input  logic [3:0]        reg_read_addr_B,
    input  logic [3:0]        reg_write_addr,
    input  logic              reg_write_enable,
    input  logic [3:0]        ALU_Sel,
    input  logic              CCR_Load,
    input  logic [1:0]        Bus1_Sel,
    input  logic [2:0]        Bus2_Sel,
    input  logic              ALU_B_Sel,
    input  logic              addr_sel,
    input  logic [DATA_W-1:0] immediate_in,
    input  logic [DATA_W-1:0] from_memory,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] address,
    output logic [DATA_W-1:0] to_memory,
    output logic [3:0]        CCR_Result,
    output logic [DATA_W-1:0] pc_out
);

    // Returns {N,Z,V,C,result[7:0]}. Carry for subtraction is the borrow,
    // which is bit 8 of the 9-bit difference.
    function automatic logic [11:0] alu_f(input logic [3:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        logic [8:0] wide;
        logic [7:0] r;
        logic       v;
        logic       c;
        wide = 9'd0;
        r    = a;
        v    = 1'b0;
        c    = 1'b0;
        case (op)
            4'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[7:0];
                c    = wide[8];
                v    = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'd1: begin
                wide = {1'b0, a} - {1'b0, b};
                r    = wide[7:0];
                c    = wide[8];
                v    = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd6: r = a ^ b;
            4'd7: begin
                wide = {1'b0, a} + 9'd1;
                r    = wide[7:0];
                c    = wide[8];
                v    = (a[7] == 1'b0) && (r[7] == 1'b1);
            end
            4'd8: begin
                wide = {1'b0, a} - 9'd1;
                r    = wide[7:0];
                c    = wide[8];
                v    = (a[7] == 1'b1) && (r[7] == 1'b0);
            end
            default: r = a;
        endcase
        return {r[7], (r == 8'h00), v, c, r};
    endfunction

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] btl_q, btl_d;
    logic [3:0]        ccr_q, ccr_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic [DATA_W-1:0] ra_s, rb_s, bus1_s, bus2_s;
    logic [DATA_W-1:0] alu_a_s, alu_b_s, alu_r_s;
    logic [3:0]        alu_flags_s;

    assign ra_s = regs_q[reg_read_addr_A];
    assign rb_s = regs_q[reg_read_addr_B];

    // Bus1 source select
    always_comb begin
        bus1_s = pc_q;
        case (Bus1_Sel)
            2'd0:    bus1_s = pc_q;
            2'd1:    bus1_s = ra_s;
            2'd2:    bus1_s = rb_s;
            2'd3:    bus1_s = mar_q;
            default: bus1_s = pc_q;
        endcase
    end

    // ALU operand select: normal, branch-target (PC+imm) or INC/DEC (RA,1)
    always_comb begin
        alu_a_s = bus1_s;
        alu_b_s = rb_s;
        if (!addr_sel) begin
            alu_a_s = bus1_s;
            alu_b_s = rb_s;
        end else if (ALU_B_Sel) begin
            alu_a_s = pc_q;
            alu_b_s = immediate_in;
        end else begin
            alu_a_s = ra_s;
            alu_b_s = 8'h01;
        end
    end

    assign {alu_flags_s, alu_r_s} = alu_f(ALU_Sel, alu_a_s, alu_b_s);

    // Bus2 source select; unused codes drive zero
    always_comb begin
        bus2_s = 8'h00;
        case (Bus2_Sel)
            3'd0:    bus2_s = alu_r_s;
            3'd1:    bus2_s = bus1_s;
            3'd2:    bus2_s = from_memory;
            3'd3:    bus2_s = immediate_in;
            default: bus2_s = 8'h00;
        endcase
    end

    // Next-state for every datapath register
    always_comb begin
        pc_d  = pc_q;
        mar_d = mar_q;
        ir_d  = ir_q;
        btl_d = btl_q;
        ccr_d = ccr_q;
        regs_d = regs_q;
        if (PC_Load) begin
            pc_d = btl_q;
        end else if (PC_Inc) begin
            pc_d = pc_q + 8'd1;
        end else begin
            pc_d = pc_q;
        end
        if (MAR_Load) mar_d = bus2_s; else mar_d = mar_q;
        if (IR_Load)  ir_d  = bus2_s; else ir_d  = ir_q;
        if (CCR_Load) ccr_d = alu_flags_s; else ccr_d = ccr_q;
        if (addr_sel && ALU_B_Sel) btl_d = alu_r_s; else btl_d = btl_q;
        if (reg_write_enable) begin
            regs_d[reg_write_addr] = bus2_s;
        end else begin
            regs_d = regs_q;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= 8'h00;
            mar_q <= 8'h00;
            ir_q  <= 8'h00;
            btl_q <= 8'h00;
            ccr_q <= 4'h0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            pc_q   <= pc_d;
            mar_q  <= mar_d;
            ir_q   <= ir_d;
            btl_q  <= btl_d;
            ccr_q  <= ccr_d;
            regs_q <= regs_d;
        end
    end

    assign IR         = ir_q;
    assign address    = mar_q;
    assign pc_out     = pc_q;
    assign CCR_Result = ccr_q;
    assign to_memory  = bus1_s;

endmodule

// File: tb/tb_cpu_data_path.sv
`timescale 1ns/1ps
module tb_cpu_data_path;
    logic       clk = 1'b0;
    logic       reset;
    logic       IR_Load, MAR_Load, PC_Load, PC_Inc;
    logic [3:0] reg_read_addr_A, reg_read_addr_B, reg_write_addr;
    logic       reg_write_enable;
    logic [3:0] ALU_Sel;
    logic       CCR_Load;
    logic [1:0] Bus1_Sel;
    logic [2:0] Bus2_Sel;
    logic       ALU_B_Sel, addr_sel;
    logic [7:0] immediate_in, from_memory;
    logic [7:0] IR, address, to_memory, pc_out;
    logic [3:0] CCR_Result;

    int errors = 0;
    int checks = 0;

    // reference state
    logic [7:0] m_regs [16];
    logic [7:0] m_pc, m_mar, m_ir, m_btl;
    logic [3:0] m_ccr;

    always #5 clk = ~clk;

    cpu_data_path dut (
        .clk(clk), .reset(reset),
        .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
        .reg_read_addr_A(reg_read_addr_A), .reg_read_addr_B(reg_read_addr_B),
        .reg_write_addr(reg_write_addr), .reg_write_enable(reg_write_enable),
        .ALU_Sel(ALU_Sel), .CCR_Load(CCR_Load), .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel),
        .ALU_B_Sel(ALU_B_Sel), .addr_sel(addr_sel),
        .immediate_in(immediate_in), .from_memory(from_memory),
        .IR(IR), .address(address), .to_memory(to_memory),
        .CCR_Result(CCR_Result), .pc_out(pc_out)
    );

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_pc = 8'h00; m_mar = 8'h00; m_ir = 8'h00; m_btl = 8'h00; m_ccr = 4'h0;
    endtask

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // ALU computed with plain integer arithmetic
    task automatic model_alu(input int op, input int a, input int b,
                             output int r, output logic [3:0] f);
        int  s;
        int  sv;
        bit  v, c;
        v = 0; c = 0; r = a;
        case (op)
            0, 7: begin
                if (op == 7) b = 1;
                s = a + b; r = s % 256; c = (s > 255);
                sv = sgn(a) + sgn(b); v = (sv > 127) || (sv < -128);
            end
            1, 8: begin
                if (op == 8) b = 1;
                s = a - b; r = (s + 256) % 256; c = (a < b);
                sv = sgn(a) - sgn(b); v = (sv > 127) || (sv < -128);
            end
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            default: r = a;
        endcase
        f = {r >= 128, r == 0, v, c};
    endtask

    function automatic logic [7:0] m_bus1();
        case (Bus1_Sel)
            2'd0:    return m_pc;
            2'd1:    return m_regs[reg_read_addr_A];
            2'd2:    return m_regs[reg_read_addr_B];
            default: return m_mar;
        endcase
    endfunction

    task automatic clear_strobes();
        IR_Load = 1'b0; MAR_Load = 1'b0; PC_Load = 1'b0; PC_Inc = 1'b0;
        reg_read_addr_A = 4'd0; reg_read_addr_B = 4'd0; reg_write_addr = 4'd0;
        reg_write_enable = 1'b0; ALU_Sel = 4'd0; CCR_Load = 1'b0;
        Bus1_Sel = 2'd0; Bus2_Sel = 3'd0; ALU_B_Sel = 1'b0; addr_sel = 1'b0;
        immediate_in = 8'h00; from_memory = 8'h00;
    endtask

    // Advance the model by one edge using the driven inputs, then clock the DUT.
    // Called at a negedge; returns at the following negedge.
    task automatic tick();
        int a, b, r;
        logic [3:0] f;
        logic [7:0] bus1, bus2, npc;
        bus1 = m_bus1();
        if (!addr_sel) begin
            a = bus1; b = m_regs[reg_read_addr_B];
        end else if (ALU_B_Sel) begin
            a = m_pc; b = immediate_in;
        end else begin
            a = m_regs[reg_read_addr_A]; b = 1;
        end
        model_alu(ALU_Sel, a, b, r, f);
        case (Bus2_Sel)
            3'd0: bus2 = r[7:0];
            3'd1: bus2 = bus1;
            3'd2: bus2 = from_memory;
            3'd3: bus2 = immediate_in;
            default: bus2 = 8'h00;
        endcase
        npc = PC_Load ? m_btl : (PC_Inc ? 8'((m_pc + 1) % 256) : m_pc);
        if (addr_sel && ALU_B_Sel) m_btl = r[7:0];
        if (CCR_Load) m_ccr = f;
        if (MAR_Load) m_mar = bus2;
        if (IR_Load) m_ir = bus2;
        if (reg_write_enable) m_regs[reg_write_addr] = bus2;
        m_pc = npc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_reg(input logic [3:0] idx, input logic [7:0] val);
        clear_strobes();
        reg_write_enable = 1'b1; reg_write_addr = idx;
        Bus2_Sel = 3'd3; immediate_in = val;
        tick();
        clear_strobes();
    endtask

    // Steer PC to target through the branch latch (PC + offset, then PC_Load)
    task automatic set_pc(input logic [7:0] target);
        clear_strobes();
        addr_sel = 1'b1; ALU_B_Sel = 1'b1; ALU_Sel = 4'd0;
        immediate_in = target - m_pc;
        tick();
        clear_strobes();
        PC_Load = 1'b1;
        tick();
        clear_strobes();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_strobes();
        IR_Load = 1'b1; MAR_Load = 1'b1; PC_Inc = 1'b1; CCR_Load = 1'b1;
        reg_write_enable = 1'b1; Bus2_Sel = 3'd3; immediate_in = 8'hAA;
        ALU_Sel = 4'd1; Bus1_Sel = 2'd0;
        repeat (3) @(negedge clk);
        checks++; if (IR !== 8'h00) begin errors++; $display("FAIL reset_ir got=%h exp=00", IR); end
        checks++; if (address !== 8'h00) begin errors++; $display("FAIL reset_addr got=%h exp=00", address); end
        checks++; if (pc_out !== 8'h00) begin errors++; $display("FAIL reset_pc got=%h exp=00", pc_out); end
        checks++; if (CCR_Result !== 4'h0) begin errors++; $display("FAIL reset_ccr got=%h exp=0", CCR_Result); end
        checks++; if (to_memory !== 8'h00) begin errors++; $display("FAIL reset_tomem got=%h exp=00", to_memory); end
        clear_strobes();
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_fetch();
        clear_strobes();
        MAR_Load = 1'b1; Bus2_Sel = 3'd1; Bus1_Sel = 2'd0;
        tick();
        checks++; if (address !== 8'h00) begin errors++; $display("FAIL fetch_mar got=%h exp=00", address); end
        clear_strobes();
        IR_Load = 1'b1; PC_Inc = 1'b1; Bus2_Sel = 3'd2; from_memory = 8'h80;
        tick();
        checks++; if (IR !== 8'h80) begin errors++; $display("FAIL fetch_ir got=%h exp=80", IR); end
        checks++; if (pc_out !== 8'h01) begin errors++; $display("FAIL fetch_pc got=%h exp=01", pc_out); end
        clear_strobes();
    endtask

    task automatic test_add();
        write_reg(4'd1, 8'h05);
        write_reg(4'd2, 8'hFC);
        ALU_Sel = 4'd0; Bus1_Sel = 2'd1; reg_read_addr_A = 4'd1; reg_read_addr_B = 4'd2;
        Bus2_Sel = 3'd0; reg_write_enable = 1'b1; reg_write_addr = 4'd1; CCR_Load = 1'b1;
        tick();
        checks++; if (CCR_Result !== 4'b0001) begin errors++; $display("FAIL add_ccr got=%b exp=0001", CCR_Result); end
        clear_strobes();
        Bus1_Sel = 2'd1; reg_read_addr_A = 4'd1; #1;
        checks++; if (to_memory !== 8'h01) begin errors++; $display("FAIL add_r1 got=%h exp=01", to_memory); end
    endtask

    task automatic test_sub_zero();
        write_reg(4'd3, 8'h2A);
        write_reg(4'd4, 8'h2A);
        ALU_Sel = 4'd1; Bus1_Sel = 2'd1; reg_read_addr_A = 4'd3; reg_read_addr_B = 4'd4;
        Bus2_Sel = 3'd0; reg_write_enable = 1'b1; reg_write_addr = 4'd3; CCR_Load = 1'b1;
        tick();
        checks++; if (CCR_Result !== 4'b0100) begin errors++; $display("FAIL sub_ccr got=%b exp=0100", CCR_Result); end
        clear_strobes();
        Bus1_Sel = 2'd1; reg_read_addr_A = 4'd3; #1;
        checks++; if (to_memory !== 8'h00) begin errors++; $display("FAIL sub_r3 got=%h exp=00", to_memory); end
    endtask

    task automatic test_inc_dec();
        write_reg(4'd5, 8'h7F);
        addr_sel = 1'b1; ALU_B_Sel = 1'b0; reg_read_addr_A = 4'd5; ALU_Sel = 4'd7;
        Bus2_Sel = 3'd0; reg_write_enable = 1'b1; reg_write_addr = 4'd5; CCR_Load = 1'b1;
        Bus1_Sel = 2'd1; #1;
        checks++; if (to_memory !== 8'h7F) begin errors++; $display("FAIL inc_old_read got=%h exp=7F", to_memory); end
        tick();
        checks++; if (to_memory !== 8'h80) begin errors++; $display("FAIL inc_new_read got=%h exp=80", to_memory); end
        checks++; if (CCR_Result !== 4'b1010) begin errors++; $display("FAIL inc_ccr got=%b exp=1010", CCR_Result); end
        write_reg(4'd6, 8'h00);
        addr_sel = 1'b1; ALU_B_Sel = 1'b0; reg_read_addr_A = 4'd6; ALU_Sel = 4'd8;
        Bus2_Sel = 3'd0; reg_write_enable = 1'b1; reg_write_addr = 4'd6; CCR_Load = 1'b1;
        Bus1_Sel = 2'd1;
        tick();
        checks++; if (to_memory !== 8'hFF) begin errors++; $display("FAIL dec_result got=%h exp=FF", to_memory); end
        checks++; if (CCR_Result !== 4'b1001) begin errors++; $display("FAIL dec_ccr got=%b exp=1001", CCR_Result); end
        clear_strobes();
    endtask

    task automatic test_branch();
        set_pc(8'h10);
        checks++; if (pc_out !== 8'h10) begin errors++; $display("FAIL branch_setpc got=%h exp=10", pc_out); end
        addr_sel = 1'b1; ALU_B_Sel = 1'b1; ALU_Sel = 4'd0; immediate_in = 8'hFE;
        tick();
        clear_strobes();
        PC_Load = 1'b1; PC_Inc = 1'b1;
        tick();
        checks++; if (pc_out !== 8'h0E) begin errors++; $display("FAIL branch_load_wins got=%h exp=0E", pc_out); end
        clear_strobes();
    endtask

    task automatic test_wrap_reset();
        set_pc(8'hFF);
        PC_Inc = 1'b1;
        tick();
        checks++; if (pc_out !== 8'h00) begin errors++; $display("FAIL pc_wrap got=%h exp=00", pc_out); end
        clear_strobes();
        // populate IR, CCR, R7 and PC with non-zero values
        Bus2_Sel = 3'd3; immediate_in = 8'h9C; IR_Load = 1'b1;
        reg_write_enable = 1'b1; reg_write_addr = 4'd7; PC_Inc = 1'b1;
        CCR_Load = 1'b1; ALU_Sel = 4'd0; Bus1_Sel = 2'd0; reg_read_addr_B = 4'd2;
        tick();
        clear_strobes();
        checks++; if (IR !== 8'h9C || CCR_Result !== m_ccr || pc_out !== 8'h01) begin
            errors++; $display("FAIL prereset_state got=%h/%b/%h exp=9C/%b/01", IR, CCR_Result, pc_out, m_ccr);
        end
        #2 reset = 1'b0;
        #1;
        checks++; if (pc_out !== 8'h00 || CCR_Result !== 4'h0 || IR !== 8'h00) begin
            errors++; $display("FAIL async_reset got=%h/%b/%h exp=00/0000/00", pc_out, CCR_Result, IR);
        end
        Bus1_Sel = 2'd1;
        for (int i = 0; i < 16; i++) begin
            reg_read_addr_A = 4'(i);
            #1;
            checks++; if (to_memory !== 8'h00) begin errors++; $display("FAIL async_reset_reg%0d got=%h exp=00", i, to_memory); end
        end
        @(negedge clk);
        clear_strobes();
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            IR_Load = 1'($urandom_range(0, 1)); MAR_Load = 1'($urandom_range(0, 1));
            PC_Load = ($urandom_range(0, 3) == 0); PC_Inc = 1'($urandom_range(0, 1));
            reg_read_addr_A = 4'($urandom); reg_read_addr_B = 4'($urandom);
            reg_write_addr = 4'($urandom); reg_write_enable = 1'($urandom_range(0, 1));
            ALU_Sel = 4'($urandom); CCR_Load = 1'($urandom_range(0, 1));
            Bus1_Sel = 2'($urandom); Bus2_Sel = 3'($urandom);
            ALU_B_Sel = 1'($urandom_range(0, 1)); addr_sel = 1'($urandom_range(0, 1));
            immediate_in = 8'($urandom); from_memory = 8'($urandom);
            #1;
            checks++; if (to_memory !== m_bus1()) begin errors++; $display("FAIL rnd_tomem[%0d] got=%h exp=%h", n, to_memory, m_bus1()); end
            tick();
            checks++; if (IR !== m_ir || address !== m_mar || pc_out !== m_pc || CCR_Result !== m_ccr) begin
                errors++;
                $display("FAIL rnd_state[%0d] ir=%h/%h mar=%h/%h pc=%h/%h ccr=%b/%b (got/exp)",
                         n, IR, m_ir, address, m_mar, pc_out, m_pc, CCR_Result, m_ccr);
            end
        end
        clear_strobes();
        Bus1_Sel = 2'd2;
        for (int i = 0; i < 16; i++) begin
            reg_read_addr_B = 4'(i);
            #1;
            checks++; if (to_memory !== m_regs[i]) begin errors++; $display("FAIL rnd_reg%0d got=%h exp=%h", i, to_memory, m_regs[i]); end
        end
    endtask

    initial begin
        clear_strobes();
        model_reset();
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_fetch();
        test_add();
        test_sub_zero();
        test_inc_dec();
        test_branch();
        test_wrap_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
